// File: rtl/nios2_mul_seq_if.sv
// Request/response handshake bundle between a multiply requester and nios2_mul_seq.
interface nios2_mul_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;

    modport master (
        output req_valid, req_op, req_src1, req_src2, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/nios2_mul_seq.sv
// Multiply sequencer feeding the Nios II multiply cell: one pass for MUL, four
// 16x16 partial-product passes plus signed correction for the MULX* high word.
module nios2_mul_seq #(
    parameter int MUL_LATENCY = 1
) (
    input  logic           clk,
    input  logic           reset,
    nios2_mul_seq_if.slave bus,
    output logic [31:0]    A_mul_src1,
    output logic [31:0]    A_mul_src2,
    input  logic [31:0]    A_mul_cell_result
);
    localparam logic [2:0] LAST_CNT = 3'(MUL_LATENCY);
    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULXSS = 2'b11;

    typedef enum logic [1:0] {IDLE, PASS, FIX, DONE} state_t;

    state_t      state;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] acc;
    logic [1:0]  pass;
    logic [2:0]  cnt;
    logic [63:0] addend;
    logic [31:0] corr_a;
    logic [31:0] corr_b;
    logic [31:0] high_fixed;

    // Pass p multiplies a-half p[0] by b-half p[1], both zero-extended.
    function automatic logic [63:0] half_operands(input logic [1:0] p,
                                                  input logic [31:0] x,
                                                  input logic [31:0] y);
        logic [15:0] hx;
        logic [15:0] hy;
        hx = p[0] ? x[31:16] : x[15:0];
        hy = p[1] ? y[31:16] : y[15:0];
        return {16'h0, hx, 16'h0, hy};
    endfunction

    always_comb begin
        addend = '0;
        case (pass)
            2'd0:       addend = {32'h0, A_mul_cell_result};
            2'd1, 2'd2: addend = {16'h0, A_mul_cell_result, 16'h0};
            default:    addend = {A_mul_cell_result, 32'h0};
        endcase
    end

    // Unsigned high word corrected for whichever operands are treated as signed.
    always_comb begin
        corr_a     = (op[1] && a[31]) ? b : '0;
        corr_b     = ((op == OP_MULXSS) && b[31]) ? a : '0;
        high_fixed = acc[63:32] - corr_a - corr_b;
    end

    assign bus.req_ready = (state == IDLE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            op             <= OP_MUL;
            a              <= '0;
            b              <= '0;
            acc            <= '0;
            pass           <= '0;
            cnt            <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            A_mul_src1     <= '0;
            A_mul_src2     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op    <= bus.req_op;
                        a     <= bus.req_src1;
                        b     <= bus.req_src2;
                        acc   <= '0;
                        pass  <= '0;
                        cnt   <= '0;
                        state <= PASS;
                        if (bus.req_op == OP_MUL) begin
                            A_mul_src1 <= bus.req_src1;
                            A_mul_src2 <= bus.req_src2;
                        end else begin
                            {A_mul_src1, A_mul_src2} <= half_operands(2'd0, bus.req_src1, bus.req_src2);
                        end
                    end
                end
                PASS: begin
                    if (cnt == LAST_CNT) begin
                        cnt <= '0;
                        if (op == OP_MUL) begin
                            bus.rsp_result <= A_mul_cell_result;
                            bus.rsp_valid  <= 1'b1;
                            A_mul_src1     <= '0;
                            A_mul_src2     <= '0;
                            state          <= DONE;
                        end else begin
                            acc <= acc + addend;
                            if (pass == 2'd3) begin
                                A_mul_src1 <= '0;
                                A_mul_src2 <= '0;
                                state      <= FIX;
                            end else begin
                                pass <= pass + 2'd1;
                                {A_mul_src1, A_mul_src2} <= half_operands(pass + 2'd1, a, b);
                            end
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                FIX: begin
                    bus.rsp_result <= high_fixed;
                    bus.rsp_valid  <= 1'b1;
                    state          <= DONE;
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nios2_mul_seq.sv
// Bench for nios2_mul_seq: directed table and corner sequences at latency 1,
// randomized traffic against a 64-bit reference at latency 3.
module tb_nios2_mul_seq;
    typedef struct {
        logic [31:0] result;
        int          lat;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] m1_src1, m1_src2, cell1;
    logic [31:0] m3_src1, m3_src2;
    logic [31:0] c3 [3];

    exp_t        q1[$];
    exp_t        q3[$];
    vec_t        vecs[12];
    logic [31:0] p_s1[4];
    logic [31:0] p_s2[4];

    nios2_mul_seq_if b1();
    nios2_mul_seq_if b3();

    nios2_mul_seq #(.MUL_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .bus(b1),
        .A_mul_src1(m1_src1), .A_mul_src2(m1_src2), .A_mul_cell_result(cell1)
    );

    nios2_mul_seq #(.MUL_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .bus(b3),
        .A_mul_src1(m3_src1), .A_mul_src2(m3_src2), .A_mul_cell_result(c3[2])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Multiply cell models: low 32 bits of the product, 1 and 3 cycles late.
    always @(posedge clk) begin
        cell1 <= m1_src1 * m1_src2;
        c3[0] <= m3_src1 * m3_src2;
        c3[1] <= c3[0];
        c3[2] <= c3[1];
    end

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ua, ub, sa, sb, p;
        ua = {32'h0, a};
        ub = {32'h0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            2'd0: begin p = ua * ub; return p[31:0]; end
            2'd1: p = ua * ub;
            2'd2: p = sa * ub;
            default: p = sa * sb;
        endcase
        return p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp, input int lat, input bit push);
        bit ok = 0;
        @(posedge clk) #1;
        b1.req_valid = 1'b1;
        b1.req_op    = op;
        b1.req_src1  = a;
        b1.req_src2  = b;
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if (b1.req_ready) begin ok = 1; break; end
        end
        if (!ok) checkOutput("accept_timeout", b1.req_ready, 1);
        else if (push) q1.push_back('{result: exp, lat: lat});
        @(posedge clk) #1;
        b1.req_valid = 1'b0;
        b1.req_src1  = ~a;
        b1.req_src2  = ~b;
    endtask

    task automatic waitDone1();
        int w = 0;
        while (q1.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (q1.size() != 0) begin
            checkOutput("response_timeout", 64'(q1.size()), 0);
            q1.delete();
        end
    endtask

    // Latency-1 monitor: latency, result, hold-while-valid and req_ready behaviour.
    bit          busy1, rv1_prev, rr1_prev, hs1;
    int          acc1_cyc, hs1_cyc;
    logic [31:0] last1;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy1 = 0; rv1_prev = 0; rr1_prev = 0; hs1 = 0;
        end else begin
            if (busy1) checkOutput("ready_low_while_busy", b1.req_ready, 0);
            if (b1.req_ready && !rr1_prev && hs1) begin
                checkOutput("ready_after_handshake", cyc, hs1_cyc + 1);
                hs1 = 0;
            end
            if (b1.req_valid && b1.req_ready) begin acc1_cyc = cyc; busy1 = 1; end
            if (b1.rsp_valid && !rv1_prev) begin
                if (q1.size() == 0) checkOutput("unexpected_rsp", b1.rsp_valid, 0);
                else checkOutput("latency", cyc - acc1_cyc, q1[0].lat);
            end
            if (b1.rsp_valid && rv1_prev) checkOutput("rsp_hold", b1.rsp_result, last1);
            if (b1.rsp_valid && b1.rsp_ready) begin
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    checkOutput("result", b1.rsp_result, e.result);
                end
                busy1 = 0; hs1 = 1; hs1_cyc = cyc;
            end
            rv1_prev = b1.rsp_valid;
            rr1_prev = b1.req_ready;
            last1    = b1.rsp_result;
        end
    end

    // Latency-3 monitor.
    bit          rv3_prev;
    int          acc3_cyc;
    logic [31:0] last3;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            rv3_prev = 0;
        end else begin
            if (b3.req_valid && b3.req_ready) acc3_cyc = cyc;
            if (b3.rsp_valid && !rv3_prev) begin
                if (q3.size() == 0) checkOutput("l3_unexpected_rsp", b3.rsp_valid, 0);
                else checkOutput("l3_latency", cyc - acc3_cyc, q3[0].lat);
            end
            if (b3.rsp_valid && rv3_prev) checkOutput("l3_rsp_hold", b3.rsp_result, last3);
            if (b3.rsp_valid && b3.rsp_ready && q3.size() != 0) begin
                e = q3.pop_front();
                checkOutput("l3_result", b3.rsp_result, e.result);
            end
            rv3_prev = b3.rsp_valid;
            last3    = b3.rsp_result;
        end
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        bit          ok;
        int          w;

        vecs[0]  = '{2'd0, 32'h00000007, 32'h00000006, 32'h0000002A};
        vecs[1]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[2]  = '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[3]  = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vecs[4]  = '{2'd3, 32'h80000000, 32'h80000000, 32'h40000000};
        vecs[5]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[6]  = '{2'd0, 32'h00010000, 32'h00010000, 32'h00000000};
        vecs[7]  = '{2'd1, 32'h00010000, 32'h00010000, 32'h00000001};
        vecs[8]  = '{2'd2, 32'h80000000, 32'h00000002, 32'hFFFFFFFF};
        vecs[9]  = '{2'd3, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
        vecs[10] = '{2'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
        vecs[11] = '{2'd3, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFF};
        p_s1 = '{32'h2222, 32'h1111, 32'h2222, 32'h1111};
        p_s2 = '{32'h4444, 32'h4444, 32'h3333, 32'h3333};

        b1.req_valid = 0; b1.req_op = 0; b1.req_src1 = 0; b1.req_src2 = 0; b1.rsp_ready = 1;
        b3.req_valid = 0; b3.req_op = 0; b3.req_src1 = 0; b3.req_src2 = 0; b3.rsp_ready = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", b1.req_ready, 0);
        checkOutput("reset_rsp_valid", b1.rsp_valid, 0);
        checkOutput("reset_rsp_result", b1.rsp_result, 0);
        checkOutput("reset_src1", m1_src1, 0);
        checkOutput("reset_src2", m1_src2, 0);
        checkOutput("l3_reset_req_ready", b3.req_ready, 0);
        @(posedge clk) #1 reset = 0;
        @(negedge clk);
        checkOutput("ready_after_reset", b1.req_ready, 1);
        checkOutput("l3_ready_after_reset", b3.req_ready, 1);

        $display("[TB] directed table, latency 1");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, (vecs[i].op == 2'd0) ? 3 : 10, 1);
            waitDone1();
        end

        $display("[TB] partial-product operand order");
        applyStimulus(2'd1, 32'h11112222, 32'h33334444, ref_result(2'd1, 32'h11112222, 32'h33334444), 10, 1);
        b1.req_valid = 1'b1; b1.req_op = 2'd0; b1.req_src1 = 32'hDEADBEEF; b1.req_src2 = 32'h12345678;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("pass_src1", m1_src1, p_s1[k / 2]);
            checkOutput("pass_src2", m1_src2, p_s2[k / 2]);
        end
        @(posedge clk) #1 b1.req_valid = 1'b0;
        @(negedge clk);
        checkOutput("fix_src1", m1_src1, 0);
        checkOutput("fix_src2", m1_src2, 0);
        @(negedge clk);
        checkOutput("done_src1", m1_src1, 0);
        checkOutput("done_valid", b1.rsp_valid, 1);
        waitDone1();

        $display("[TB] back-pressure");
        b1.rsp_ready = 1'b0;
        applyStimulus(2'd3, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFF, 10, 1);
        ok = 0;
        for (w = 0; w < 50; w++) begin
            @(negedge clk);
            if (b1.rsp_valid) begin ok = 1; break; end
        end
        checkOutput("bp_valid_seen", ok, 1);
        checkOutput("bp_result_0", b1.rsp_result, 32'hFFFFFFFF);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_valid_held", b1.rsp_valid, 1);
            checkOutput("bp_result_held", b1.rsp_result, 32'hFFFFFFFF);
        end
        @(posedge clk) #1 b1.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_hs_ready", b1.req_ready, 0);
        checkOutput("bp_hs_valid", b1.rsp_valid, 1);
        @(negedge clk);
        checkOutput("bp_after_ready", b1.req_ready, 1);
        checkOutput("bp_after_valid", b1.rsp_valid, 0);
        waitDone1();

        $display("[TB] reset during pass 2");
        applyStimulus(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 10, 0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checkOutput("p2_src1", m1_src1, 32'h0000FFFF);
        @(posedge clk) #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("mid_reset_valid", b1.rsp_valid, 0);
        checkOutput("mid_reset_src1", m1_src1, 0);
        checkOutput("mid_reset_src2", m1_src2, 0);
        checkOutput("mid_reset_ready", b1.req_ready, 1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checkOutput("no_rsp_after_reset", b1.rsp_valid, 0);
        end
        applyStimulus(2'd0, 32'd2, 32'd3, 32'd6, 3, 1);
        waitDone1();

        $display("[TB] random traffic, latency 3");
        for (int i = 0; i < 1000; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            @(posedge clk) #1;
            b3.req_valid = 1'b1; b3.req_op = op; b3.req_src1 = a; b3.req_src2 = b;
            ok = 0;
            for (w = 0; w < 100; w++) begin
                @(negedge clk);
                if (b3.req_ready) begin ok = 1; break; end
            end
            if (!ok) checkOutput("l3_accept_timeout", b3.req_ready, 1);
            else q3.push_back('{result: ref_result(op, a, b), lat: (op == 2'd0) ? 5 : 18});
            @(posedge clk) #1;
            b3.req_valid = 1'b0; b3.req_src1 = $urandom; b3.req_src2 = $urandom;
            w = 0;
            while (q3.size() != 0 && w < 400) begin
                @(posedge clk) #1;
                b3.rsp_ready = ($urandom_range(0, 3) != 0);
                w++;
            end
            if (q3.size() != 0) begin
                checkOutput("l3_response_timeout", 64'(q3.size()), 0);
                q3.delete();
            end
            b3.rsp_ready = 1'b1;
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
